// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state encoding and default width for the serial subtractor
package serial_sub_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit full subtractor slice (d = a - b - bin)
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor, one slice plus borrow flop
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  // Only WIDTH-1 result bits are ever stored; the last bit goes straight to D.
  logic [WIDTH-2:0] sd_q, sd_d;
  logic             borrow_q, borrow_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             v_q, v_d;

  logic             slice_d;
  logic             slice_bout;
  logic [WIDTH-1:0] sd_shift;

  full_subtractor u_slice (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .bin  (borrow_q),
    .d    (slice_d),
    .bout (slice_bout)
  );

  // Result register after this cycle's bit shifts in at the MSB.
  assign sd_shift = {slice_d, sd_q};

  assign Busy = (state_q == ST_RUN);
  assign Done = (state_q == ST_DONE);
  assign D    = d_q;
  assign Bout = bout_q;
  assign V    = v_q;

  // Next-state and datapath update: capture in IDLE, one bit per RUN cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sd_d     = sd_q;
    borrow_d = borrow_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    d_d      = d_q;
    bout_d   = bout_q;
    v_d      = v_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d  = ST_RUN;
          sa_d     = A;
          sb_d     = B;
          a_msb_d  = A[WIDTH-1];
          b_msb_d  = B[WIDTH-1];
          borrow_d = 1'b0;
          cnt_d    = '0;
        end
      end
      ST_RUN: begin
        sa_d     = {1'b0, sa_q[WIDTH-1:1]};
        sb_d     = {1'b0, sb_q[WIDTH-1:1]};
        sd_d     = sd_shift[WIDTH-1:1];
        borrow_d = slice_bout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          d_d     = sd_shift;
          bout_d  = slice_bout;
          // Operand signs differ and the result sign departs from the minuend.
          v_d     = (a_msb_q ^ b_msb_q) & (slice_d ^ a_msb_q);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation immediately.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sa_q     <= '0;
      sb_q     <= '0;
      sd_q     <= '0;
      borrow_q <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      d_q      <= '0;
      bout_q   <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sd_q     <= sd_d;
      borrow_q <= borrow_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      d_q      <= d_d;
      bout_q   <= bout_d;
      v_q      <= v_d;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor
module tb_serial_subtractor;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] d;
    logic         bout;
    logic         v;
    int           cyc;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         Start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Busy;
  logic         Done;
  logic [W-1:0] D;
  logic         Bout;
  logic         V;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   n_push = 0;
  int   n_done = 0;
  int   busy_cnt = 0;
  exp_t q[$];
  exp_t e_mon;
  logic [W+1:0] prev_out = '0;

  serial_subtractor #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .Start (Start),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .Done  (Done),
    .D     (D),
    .Bout  (Bout),
    .V     (V)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t r;
    int   sa, sb, sr;
    sa = $signed(a);
    sb = $signed(b);
    sr = sa - sb;
    r.d    = a - b;
    r.bout = (a < b);
    r.v    = (sr > 7) || (sr < -8);
    r.cyc  = 0;
    return r;
  endfunction

  // Called at a negedge; leaves at the negedge just before the earliest next accept.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ed, input logic eb, input logic ev,
                       input bit keep_high);
    exp_t e;
    Start = 1'b1;
    A = a;
    B = b;
    e.d = ed;
    e.bout = eb;
    e.v = ev;
    e.cyc = cyc + 1 + W;
    q.push_back(e);
    n_push++;
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge CLK);
      if (!keep_high) Start = 1'b0;
      A = W'($urandom_range(0, 15));
      B = W'($urandom_range(0, 15));
    end
    @(negedge CLK);
  endtask

  // Monitor: pops on every Done pulse, otherwise checks that results hold.
  always @(negedge CLK) begin
    if (!RST_N) begin
      busy_cnt = 0;
      prev_out = {D, Bout, V};
    end else begin
      if (Busy) busy_cnt++;
      if (Done) begin
        n_done++;
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(Done), 32'd0);
        end else begin
          e_mon = q.pop_front();
          chk("D", 32'(D), 32'(e_mon.d));
          chk("Bout", 32'(Bout), 32'(e_mon.bout));
          chk("V", 32'(V), 32'(e_mon.v));
          chk("done_cycle", 32'(cyc), 32'(e_mon.cyc));
          chk("busy_cycles", 32'(busy_cnt), 32'(W));
          chk("busy_in_done", 32'(Busy), 32'd0);
        end
        busy_cnt = 0;
      end else begin
        chk("hold", 32'({D, Bout, V}), 32'(prev_out));
      end
      prev_out = {D, Bout, V};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t m;
    repeat (3) @(negedge CLK);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_D", 32'(D), 32'd0);
    chk("rst_Bout", 32'(Bout), 32'd0);
    chk("rst_V", 32'(V), 32'd0);
    @(posedge CLK);
    #2 RST_N = 1'b1;
    @(negedge CLK);

    // Pulsed Start, hand-computed results.
    issue(4'b1001, 4'b0011, 4'b0110, 1'b0, 1'b1, 1'b0);  // -7 - 3 overflows
    issue(4'b0011, 4'b1001, 4'b1010, 1'b1, 1'b1, 1'b0);  // 3 - (-7) overflows
    issue(4'b0111, 4'b1000, 4'b1111, 1'b1, 1'b1, 1'b0);  // 7 - (-8)

    // Start held high, operands toggling during RUN.
    issue(4'b1100, 4'b0101, 4'b0111, 1'b0, 1'b1, 1'b1);
    issue(4'b0010, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1);
    issue(4'b0000, 4'b0001, 4'b1111, 1'b1, 1'b0, 1'b1);
    issue(4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b1, 1'b1);
    Start = 1'b0;
    repeat (2) @(negedge CLK);

    // Reset in cycle 2 of RUN: outputs clear at once, no Done follows.
    Start = 1'b1;
    A = 4'b0101;
    B = 4'b0010;
    @(negedge CLK);
    Start = 1'b0;
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_done", 32'(Done), 32'd0);
    chk("abort_D", 32'(D), 32'd0);
    chk("abort_Bout", 32'(Bout), 32'd0);
    chk("abort_V", 32'(V), 32'd0);
    @(posedge CLK);
    #2 RST_N = 1'b1;
    repeat (10) @(negedge CLK);
    issue(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

    // All operand pairs back to back against the arithmetic model.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        m = model(W'(a), W'(b));
        issue(W'(a), W'(b), m.d, m.bout, m.v, 1'b1);
      end
    end
    Start = 1'b0;
    repeat (4) @(negedge CLK);

    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("done_count", 32'(n_done), 32'(n_push));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
